// File: rtl/dma_mem_arbiter_pkg.sv
// Shared definitions for the DMNI memory arbiter: requester count and requester ids.
package DMNIPkg;

  localparam int unsigned MEM_N_REQ = 3;

  typedef enum logic [1:0] {
    MEM_REQ_HRX,
    MEM_REQ_HTX,
    MEM_REQ_BRMON
  } mem_req_id_t;

endpackage

// File: rtl/dma_mem_arbiter_rr_picker.sv
// Round-robin picker: first eligible request after the pointer, wrapping modulo N.
module rr_picker #(
  parameter int unsigned N    = 3,
  parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  input  logic [N-1:0]    excl_i,
  output logic [N-1:0]    gnt_o
);

  logic [N-1:0]    elig;
  logic [PtrW-1:0] idx;
  logic            found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    elig  = req_i & ~excl_i;
    // k = N revisits the pointer itself, so it has the lowest priority
    for (int unsigned k = 1; k <= N; k++) begin
      idx = PtrW'((32'(ptr_i) + k) % N);
      if (!found && elig[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_mem_arbiter.sv
// Single-port memory arbiter: round-robin grant with bounded locked bursts and a 1-cycle read return.
module dma_mem_arbiter
  import DMNIPkg::*;
#(
  parameter int unsigned N_REQ     = MEM_N_REQ,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ-1:0]       lock_i,
  input  logic [N_REQ-1:0][3:0]  we_i,
  input  logic [N_REQ-1:0][31:0] addr_i,
  input  logic [N_REQ-1:0][31:0] wdata_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       rvalid_o,
  output logic [31:0]            rdata_o,
  output logic [3:0]             mem_we_o,
  output logic [31:0]            mem_addr_o,
  output logic [31:0]            mem_data_o,
  input  logic [31:0]            mem_data_i,
  output logic                   busy_o
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  logic [IdxW-1:0]  owner_q, owner_d, last_q, last_d, gnt_idx;
  logic             locked_q, locked_d;
  logic [CntW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [N_REQ-1:0] rvalid_q, rvalid_d;

  logic [N_REQ-1:0] owner_oh, excl, rr_gnt, gnt;
  logic             others, at_max, starve, keep;

  rr_picker #(
    .N    (N_REQ),
    .PtrW (IdxW)
  ) u_rr_picker (
    .req_i  (req_i),
    .ptr_i  (last_q),
    .excl_i (excl),
    .gnt_o  (rr_gnt)
  );

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    others            = |(req_i & ~owner_oh);
    at_max            = (beat_cnt_q == CntW'(MAX_BURST));
    starve            = locked_q & req_i[owner_q] & at_max & others;
    keep              = locked_q & req_i[owner_q] & ~starve;
    excl              = starve ? owner_oh : '0;
    // A dropped lock falls straight through to round-robin, so no idle cycle
    gnt               = rst_i ? '0 : (keep ? owner_oh : rr_gnt);
    gnt_idx           = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) gnt_idx = IdxW'(i);
    end
  end

  always_comb begin
    owner_d    = owner_q;
    last_d     = last_q;
    locked_d   = locked_q;
    beat_cnt_d = beat_cnt_q;
    rvalid_d   = '0;
    if (|gnt) begin
      last_d   = gnt_idx;
      owner_d  = gnt_idx;
      locked_d = lock_i[gnt_idx];
      if ((gnt_idx == owner_q) && locked_q) begin
        beat_cnt_d = at_max ? CntW'(1) : beat_cnt_q + CntW'(1);
      end else begin
        beat_cnt_d = CntW'(1);
      end
      if (we_i[gnt_idx] == 4'b0000) rvalid_d = gnt;
    end else begin
      locked_d = 1'b0;
    end
  end

  always_comb begin
    mem_we_o   = '0;
    mem_addr_o = '0;
    mem_data_o = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        mem_we_o   = we_i[i];
        mem_addr_o = addr_i[i];
        mem_data_o = wdata_i[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q    <= '0;
      last_q     <= IdxW'(N_REQ - 1);
      locked_q   <= 1'b0;
      beat_cnt_q <= '0;
      rvalid_q   <= '0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      locked_q   <= locked_d;
      beat_cnt_q <= beat_cnt_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // Gating with rst_i hides a read return that was already in flight when reset arrived
  assign gnt_o    = gnt;
  assign rvalid_o = rst_i ? '0 : rvalid_q;
  assign rdata_o  = (|rvalid_o) ? mem_data_i : '0;
  assign busy_o   = locked_q & ~rst_i;

endmodule

// File: tb/tb_dma_mem_arbiter.sv
// Directed bench for dma_mem_arbiter: round-robin, read return, burst limit, lock hand-off, reset.
module tb_dma_mem_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       req, lock;
  logic [2:0][3:0]  we;
  logic [2:0][31:0] addr, wdata;
  logic [2:0]       gnt, rvalid;
  logic [31:0]      rdata, mem_addr, mem_data, mem_rd;
  logic [3:0]       mem_we;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  dma_mem_arbiter #(
    .N_REQ     (3),
    .MAX_BURST (16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .lock_i     (lock),
    .we_i       (we),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .gnt_o      (gnt),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_data),
    .mem_data_i (mem_rd),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'hCAFE0001 : {16'hBEEF, a[15:0]};
  endfunction

  always @(posedge clk) mem_rd <= mem_model(mem_addr);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] rr_exp [4];
  int         rr_idx [4];

  initial begin
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
    rr_idx = '{0, 1, 2, 0};
    rst  = 1'b1;
    req  = '0;
    lock = '0;
    we   = '0;
    addr[0] = 32'h10; addr[1] = 32'h20; addr[2] = 32'h30;
    wdata = '0;

    // Reset state with requests already present
    next_cycle();
    req = 3'b111;
    @(negedge clk);
    check_eq("rst_gnt", 64'(gnt), 64'h0);
    check_eq("rst_rvalid", 64'(rvalid), 64'h0);
    check_eq("rst_rdata", 64'(rdata), 64'h0);
    check_eq("rst_mem", {28'h0, mem_we, mem_addr}, 64'h0);
    check_eq("rst_mem_data", 64'(mem_data), 64'h0);
    check_eq("rst_busy", 64'(busy), 64'h0);
    next_cycle();
    rst = 1'b0;

    // Plain round-robin over three reading requesters
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq($sformatf("rr_gnt%0d", c), 64'(gnt), 64'(rr_exp[c]));
      check_eq($sformatf("rr_addr%0d", c), 64'(mem_addr), 64'(addr[rr_idx[c]]));
      if (c > 0) begin
        check_eq($sformatf("rr_rvalid%0d", c), 64'(rvalid), 64'(rr_exp[c-1]));
        check_eq($sformatf("rr_rdata%0d", c), 64'(rdata), 64'(mem_model(addr[rr_idx[c-1]])));
      end
      next_cycle();
    end

    // Requester 1 reads 0x100
    req = 3'b010;
    addr[1] = 32'h100;
    @(negedge clk);
    check_eq("rd_gnt", 64'(gnt), 64'h2);
    check_eq("rd_addr", {28'h0, mem_we, mem_addr}, 64'h100);
    next_cycle();
    req = 3'b000;
    @(negedge clk);
    check_eq("rd_idle_mem", {28'h0, mem_we, mem_addr}, 64'h0);
    check_eq("rd_rvalid", 64'(rvalid), 64'h2);
    check_eq("rd_rdata", 64'(rdata), 64'hCAFE0001);
    next_cycle();

    // Write from requester 0: memory port mirrors it, no read return follows
    req = 3'b001;
    we[0] = 4'hF;
    addr[0] = 32'h40;
    wdata[0] = 32'h12345678;
    @(negedge clk);
    check_eq("wr_gnt", 64'(gnt), 64'h1);
    check_eq("wr_mem", {28'h0, mem_we, mem_addr}, {28'h0, 4'hF, 32'h40});
    check_eq("wr_data", 64'(mem_data), 64'h12345678);
    check_eq("wr_rvalid_prev", 64'(rvalid), 64'h0);
    next_cycle();
    req = 3'b000;
    we[0] = 4'h0;
    @(negedge clk);
    check_eq("wr_no_rvalid", 64'(rvalid), 64'h0);
    next_cycle();

    // Starvation limit: 0 locked, 2 waits from cycle 2 and leaves once served
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    lock = 3'b001;
    for (int c = 0; c < 20; c++) begin
      req = 3'b001 | ((c >= 2 && c <= 16) ? 3'b100 : 3'b000);
      @(negedge clk);
      check_eq($sformatf("burst_gnt%0d", c), 64'(gnt), (c == 16) ? 64'h4 : 64'h1);
      check_eq($sformatf("burst_busy%0d", c), 64'(busy), (c == 0 || c == 17) ? 64'h0 : 64'h1);
      next_cycle();
    end

    // Locked alone for 40 beats: never preempted
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    req = 3'b001;
    lock = 3'b001;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check_eq($sformatf("solo%0d", c), {60'h0, gnt, busy}, {60'h0, 3'b001, (c > 0)});
      next_cycle();
    end

    // Lock hand-off: owner 0 leaves, 1 locks, then 1 leaves while 2 requests
    req = 3'b110;
    lock = 3'b010;
    @(negedge clk);
    check_eq("ho_gnt1", 64'(gnt), 64'h2);
    next_cycle();
    @(negedge clk);
    check_eq("ho_hold1", {60'h0, gnt, busy}, {60'h0, 3'b010, 1'b1});
    next_cycle();
    req = 3'b100;
    lock = 3'b100;
    @(negedge clk);
    check_eq("ho_gnt2", {60'h0, gnt, busy}, {60'h0, 3'b100, 1'b1});
    next_cycle();
    req = 3'b000;
    lock = 3'b000;
    @(negedge clk);
    check_eq("ho_busy2", {60'h0, gnt, busy}, {60'h0, 3'b000, 1'b1});
    next_cycle();
    @(negedge clk);
    check_eq("idle_busy", 64'(busy), 64'h0);

    // Reset right after a granted read
    req = 3'b010;
    @(negedge clk);
    check_eq("pre_rst_gnt", 64'(gnt), 64'h2);
    next_cycle();
    rst = 1'b1;
    req = 3'b111;
    @(negedge clk);
    check_eq("rst2_rvalid", 64'(rvalid), 64'h0);
    check_eq("rst2_mem", {28'h0, mem_we, mem_addr}, 64'h0);
    check_eq("rst2_gnt", 64'(gnt), 64'h0);
    check_eq("rst2_rdata", 64'(rdata), 64'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_gnt", 64'(gnt), 64'h1);
    check_eq("post_rst_rvalid", 64'(rvalid), 64'h0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
